// File: rtl/sample_framer_if.sv
// Interface bundle for sample_framer: serial input side and framed output side.
// The slave modport is the framer itself; the master modport is whoever
// drives the serial line and consumes the frames.
interface sample_framer_if #(
  parameter int ERR_CNT_W = 4
) ();
  logic                 bit_en;
  logic                 ser_in;
  logic [7:0]           frame_out;
  logic                 frame_valid;
  logic                 frame_err;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 busy;

  modport master (
    output bit_en,
    output ser_in,
    input  frame_out,
    input  frame_valid,
    input  frame_err,
    input  err_cnt,
    input  busy
  );

  modport slave (
    input  bit_en,
    input  ser_in,
    output frame_out,
    output frame_valid,
    output frame_err,
    output err_cnt,
    output busy
  );
endinterface

// File: rtl/sample_framer.sv
// sample_framer: deserialises start/data/[parity]/stop frames from a serial
// sensor line into an 8-bit frame {p, t, y, x}, with a saturating error count.
// Optional feature macro: SAMPLE_FRAMER_PARITY_CHECK_EN adds an even-parity
// bit after the data bits (11-bit frame instead of 10-bit).
// rst_n is an asynchronous reset that is asserted HIGH despite its name.
module sample_framer #(
  parameter int ERR_CNT_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  sample_framer_if.slave bus
);

`ifdef SAMPLE_FRAMER_PARITY_CHECK_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    STOP   = 2'd3
  } state_t;
`endif

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

  // Even parity of a data byte: the parity bit that makes the total count even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

  state_t               state_q, state_d;
  logic [2:0]           bitcnt_q, bitcnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           frame_out_q, frame_out_d;
  logic                 frame_valid_q, frame_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
`ifdef SAMPLE_FRAMER_PARITY_CHECK_EN
  logic                 mismatch_q, mismatch_d;
`endif
  logic                 frame_ok_s;

  // State and datapath registers; reset discards any partial frame silently.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q       <= IDLE;
      bitcnt_q      <= 3'd0;
      shift_q       <= 8'h00;
      frame_out_q   <= 8'h00;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_cnt_q     <= '0;
`ifdef SAMPLE_FRAMER_PARITY_CHECK_EN
      mismatch_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      bitcnt_q      <= bitcnt_d;
      shift_q       <= shift_d;
      frame_out_q   <= frame_out_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      err_cnt_q     <= err_cnt_d;
`ifdef SAMPLE_FRAMER_PARITY_CHECK_EN
      mismatch_q    <= mismatch_d;
`endif
    end
  end

  // Accept the frame only on a 0 stop bit (and matching parity when enabled).
  always_comb begin
`ifdef SAMPLE_FRAMER_PARITY_CHECK_EN
    frame_ok_s = ~bus.ser_in & ~mismatch_q;
`else
    frame_ok_s = ~bus.ser_in;
`endif
  end

  // Next-state logic; nothing advances on edges without the bit strobe.
  always_comb begin
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    shift_d       = shift_q;
    frame_out_d   = frame_out_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    err_cnt_d     = err_cnt_q;
`ifdef SAMPLE_FRAMER_PARITY_CHECK_EN
    mismatch_d    = mismatch_q;
`endif
    if (bus.bit_en) begin
      case (state_q)
        IDLE: begin
          if (bus.ser_in) begin
            state_d  = DATA;
            bitcnt_d = 3'd0;
`ifdef SAMPLE_FRAMER_PARITY_CHECK_EN
            mismatch_d = 1'b0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
        DATA: begin
          shift_d[bitcnt_q] = bus.ser_in;
          bitcnt_d          = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
`ifdef SAMPLE_FRAMER_PARITY_CHECK_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            state_d = DATA;
          end
        end
`ifdef SAMPLE_FRAMER_PARITY_CHECK_EN
        PARITY: begin
          mismatch_d = bus.ser_in ^ even_parity(shift_q);
          state_d    = STOP;
        end
`endif
        STOP: begin
          if (frame_ok_s) begin
            frame_out_d   = shift_q;
            frame_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            if (err_cnt_q != ERR_MAX) begin
              err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end else begin
              err_cnt_d = err_cnt_q;
            end
          end
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  assign bus.frame_out   = frame_out_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.err_cnt     = err_cnt_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_sample_framer.sv
// Testbench for sample_framer: directed scenarios plus randomized frames,
// checked against a frame-level reference model.
module tb_sample_framer;
  localparam int W   = 4;
  localparam int SAT = (1 << W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  sample_framer_if #(.ERR_CNT_W(W)) bus ();

  sample_framer #(.ERR_CNT_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observed pulse statistics
  int         v_pulses = 0;
  int         e_pulses = 0;
  int         both_hi  = 0;
  logic [7:0] vq[$];

  // Reference model state
  logic [7:0] m_frame = 8'h00;
  int         m_err   = 0;
  int         m_v     = 0;
  int         m_e     = 0;
  logic [7:0] mq[$];

  // Record every output pulse while out of reset.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (bus.frame_valid) begin
        v_pulses++;
        vq.push_back(bus.frame_out);
      end
      if (bus.frame_err) e_pulses++;
      if (bus.frame_valid && bus.frame_err) both_hi++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic b);
    bus.bit_en = en;
    bus.ser_in = b;
    @(posedge clk);
    #1;
  endtask

  // One serial bit: period-1 disabled cycles carrying junk, then the strobe.
  task automatic send_bit(input logic b, input int period);
    for (int i = 1; i < period; i++) step(1'b0, 1'($urandom_range(0, 1)));
    step(1'b1, b);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int period, input string tag);
    logic good;
    send_bit(1'b1, period);
    for (int i = 0; i < 8; i++) send_bit(d[i], period);
`ifdef SAMPLE_FRAMER_PARITY_CHECK_EN
    send_bit(par, period);
    good = !stp && (par == ^d);
`else
    good = !stp;
`endif
    send_bit(stp, period);
    if (good) begin
      m_frame = d;
      m_v++;
      mq.push_back(d);
    end else begin
      m_e++;
      if (m_err < SAT) m_err++;
    end
    check({tag, "/valid"}, 32'(bus.frame_valid), 32'(good));
    check({tag, "/err"},   32'(bus.frame_err),   32'(!good));
    check({tag, "/frame"}, 32'(bus.frame_out),   32'(m_frame));
    check({tag, "/cnt"},   32'(bus.err_cnt),     32'(m_err));
    check({tag, "/busy"},  32'(bus.busy),        32'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic       par, stp;
    int         per;

    bus.bit_en = 1'b0;
    bus.ser_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst/frame", 32'(bus.frame_out),   32'h00);
    check("rst/valid", 32'(bus.frame_valid), 32'd0);
    check("rst/err",   32'(bus.frame_err),   32'd0);
    check("rst/cnt",   32'(bus.err_cnt),     32'd0);
    check("rst/busy",  32'(bus.busy),        32'd0);
    rst_n = 1'b0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("idle/busy", 32'(bus.busy), 32'd0);

    // Known good frame 8'hC6 at full bit rate
    send_frame(8'hC6, 1'b0, 1'b0, 1, "c6");
    step(1'b0, 1'b0);
    check("c6/pulse_end", 32'(bus.frame_valid), 32'd0);

`ifdef SAMPLE_FRAMER_PARITY_CHECK_EN
    // Same frame with wrong parity must be rejected and frame_out held
    send_frame(8'hC6, 1'b1, 1'b0, 1, "badpar");
    send_frame(8'h3C, 1'b0, 1'b0, 2, "goodpar");
`endif

    // Randomized frames with varying bit rate, parity and stop bits
    for (int n = 0; n < 30; n++) begin
      d   = 8'($urandom);
      par = ($urandom_range(0, 3) == 0) ? ~(^d) : ^d;
      stp = ($urandom_range(0, 3) == 0);
      per = $urandom_range(1, 3);
      send_frame(d, par, stp, per, "rand");
      for (int g = $urandom_range(0, 2); g > 0; g--) step(1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset in the middle of a frame discards it silently
    send_bit(1'b1, 1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1);
    check("mid/busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    check("mid/err",   32'(bus.frame_err), 32'd0);
    check("mid/cnt",   32'(bus.err_cnt),   32'd0);
    check("mid/frame", 32'(bus.frame_out), 32'h00);
    check("mid/busy",  32'(bus.busy),      32'd0);
    rst_n   = 1'b0;
    m_err   = 0;
    m_frame = 8'h00;
    send_frame(8'h3F, ^8'h3F, 1'b0, 1, "after_rst");
    check("mid/epulses", 32'(e_pulses), 32'(m_e));

    // Slow frame followed immediately by a full-rate frame
    send_frame(8'hC6, ^8'hC6, 1'b0, 3, "b2b_1");
    send_frame(8'h81, ^8'h81, 1'b0, 1, "b2b_2");
    step(1'b0, 1'b0);
    check("b2b/first",  32'(vq[vq.size()-2]), 32'hC6);
    check("b2b/second", 32'(vq[vq.size()-1]), 32'h81);

    // Error counter saturation
    for (int n = 0; n < 20; n++) begin
      d = 8'($urandom);
      send_frame(d, ^d, 1'b1, 1, "sat");
    end
    check("sat/cnt15", 32'(bus.err_cnt), 32'(SAT));
    send_frame(8'h55, ^8'h55, 1'b0, 1, "sat_good");
    check("sat/hold", 32'(bus.err_cnt), 32'(SAT));

    step(1'b0, 1'b0);
    check("sum/vpulses", 32'(v_pulses), 32'(m_v));
    check("sum/epulses", 32'(e_pulses), 32'(m_e));
    check("sum/both",    32'(both_hi),  32'd0);
    check("sum/qsize",   32'(vq.size()), 32'(mq.size()));
    for (int i = 0; i < mq.size() && i < vq.size(); i++)
      check("sum/value", 32'(vq[i]), 32'(mq[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
